// File: rtl/seq_pattern_detect.sv
// seq_pattern_detect
//   Serial pattern detector on a 1-bit stream. The last PAT_LEN sampled bits
//   are compared against a run-time programmable pattern (MSB = oldest bit).
//   A match produces a one-cycle registered pulse on detect and bumps a
//   saturating hit counter. In non-overlap mode a match empties the window,
//   so the next match needs PAT_LEN fresh bits.
//
// Ports
//   clk          clock, all state on posedge
//   rst          asynchronous active-high reset
//   oe           sample enable; 0 pauses the stream (state holds)
//   in           serial data bit, sampled when oe=1
//   overlap      1 = overlapping matches, 0 = non-overlapping
//   cfg_we       load cfg_pattern; clears the window, discards this cycle's bit
//   cfg_pattern  new pattern, MSB oldest
//   cnt_clr      synchronous clear of hit_cnt
//   detect       one-cycle match pulse
//   armed        window holds PAT_LEN valid bits
//   hit_cnt      saturating match count
module seq_pattern_detect #(
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b111,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               oe,
  input  logic               in,
  input  logic               overlap,
  input  logic               cfg_we,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cnt_clr,
  output logic               detect,
  output logic               armed,
  output logic [CNT_W-1:0]   hit_cnt
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               detect_q, detect_d;
  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;

  logic [PAT_LEN-1:0] window;
  logic [FILL_W-1:0]  fill_inc;
  logic               match;

  always_comb begin
    window   = {hist_q, in};
    fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    // A config write discards the sampled bit, so it can never count as a hit.
    // Fill gating keeps an all-zero pattern from matching the reset history.
    match    = oe && !cfg_we && (fill_inc == FILL_FULL) && (window == pat_q);
  end

  always_comb begin
    pat_d     = pat_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    detect_d  = 1'b0;
    hit_cnt_d = hit_cnt_q;

    if (cfg_we) begin
      pat_d  = cfg_pattern;
      hist_d = '0;
      fill_d = '0;
    end else if (oe) begin
      hist_d   = window[PAT_LEN-2:0];
      fill_d   = (match && !overlap) ? '0 : fill_inc;
      detect_d = match;
    end

    // A clear coinciding with a match keeps that match.
    if (cnt_clr) begin
      hit_cnt_d = match ? CNT_W'(1) : '0;
    end else if (match && (hit_cnt_q != CNT_MAX)) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end

    armed_d = (fill_d == FILL_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q     <= PATTERN;
      hist_q    <= '0;
      fill_q    <= '0;
      detect_q  <= 1'b0;
      armed_q   <= 1'b0;
      hit_cnt_q <= '0;
    end else begin
      pat_q     <= pat_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      detect_q  <= detect_d;
      armed_q   <= armed_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign detect  = detect_q;
  assign armed   = armed_q;
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_seq_pattern_detect.sv
module tb_seq_pattern_detect;

  logic       clk;
  logic       rst;
  logic       oe;
  logic       din;
  logic       overlap;
  logic       cfg_we;
  logic [2:0] cfg_pattern;
  logic       cnt_clr;

  logic       detect,  armed;
  logic [7:0] hit_cnt;
  logic       detect2, armed2;
  logic [1:0] hit_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  seq_pattern_detect #(.PAT_LEN(3), .PATTERN(3'b111), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .oe(oe), .in(din), .overlap(overlap),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
    .detect(detect), .armed(armed), .hit_cnt(hit_cnt)
  );

  seq_pattern_detect #(.PAT_LEN(3), .PATTERN(3'b111), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .oe(oe), .in(din), .overlap(overlap),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
    .detect(detect2), .armed(armed2), .hit_cnt(hit_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       oe;
    logic       din;
    logic       ovl;
    logic       we;
    logic [2:0] cp;
    logic       clr;
    logic       det;
    logic       arm;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic o, logic d, logic ov, logic w,
                              logic [2:0] c, logic cl, logic dt, logic a,
                              logic [7:0] n);
    vec_t v;
    v.rst = r; v.oe = o; v.din = d; v.ovl = ov; v.we = w; v.cp = c;
    v.clr = cl; v.det = dt; v.arm = a; v.cnt = n;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; oe = 1'b0; din = 1'b0; overlap = 1'b1;
    cfg_we = 1'b0; cfg_pattern = 3'b000; cnt_clr = 1'b0;

    //                 rst oe in ovl we  cp      clr det arm cnt
    // overlapping 111, five ones
    vecs.push_back(mk(1, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0, 1, 1, 2));
    vecs.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0, 1, 1, 3));
    // non-overlapping 111, six ones, then a lone clear
    vecs.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 3'b000, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 3'b000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 3'b000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 3'b000, 0, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0));
    // pause mid-match with in toggling
    vecs.push_back(mk(1, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 3'b000, 0, 0, 1, 1));
    // reprogram to 101 while the window would otherwise match 111
    vecs.push_back(mk(0, 1, 1, 1, 1, 3'b101, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 3'b000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0, 1, 1, 2));
    vecs.push_back(mk(0, 1, 0, 1, 0, 3'b000, 0, 0, 1, 2));
    vecs.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0, 1, 1, 3));
    // switch to non-overlap mid-stream
    vecs.push_back(mk(0, 1, 0, 0, 0, 3'b000, 0, 0, 1, 3));
    vecs.push_back(mk(0, 1, 1, 0, 0, 3'b000, 0, 1, 0, 4));
    // all-zero pattern needs three real bits; clear with a coincident match
    vecs.push_back(mk(0, 1, 0, 1, 1, 3'b000, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 0, 1, 0, 3'b000, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 0, 1, 0, 3'b000, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 0, 1, 0, 3'b000, 0, 1, 1, 5));
    vecs.push_back(mk(0, 1, 0, 1, 0, 3'b000, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 3'b000, 1, 0, 1, 0));

    #3;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; oe = vecs[i].oe; din = vecs[i].din;
      overlap = vecs[i].ovl; cfg_we = vecs[i].we; cfg_pattern = vecs[i].cp;
      cnt_clr = vecs[i].clr;
      tick();
      check("detect",  i, 32'(detect),  32'(vecs[i].det));
      check("armed",   i, 32'(armed),   32'(vecs[i].arm));
      check("hit_cnt", i, 32'(hit_cnt), 32'(vecs[i].cnt));
    end

    // Saturation on a 2-bit counter: seven ones give five overlapping matches.
    rst = 1'b1; oe = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    tick();
    rst = 1'b0; oe = 1'b1; din = 1'b1; overlap = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("sat_cnt2", 0, 32'(hit_cnt2), 32'd3);
    check("sat_cnt8", 0, 32'(hit_cnt),  32'd5);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_match_cnt2", 0, 32'(hit_cnt2), 32'd1);
    check("clr_match_cnt8", 0, 32'(hit_cnt),  32'd1);
    check("clr_match_det",  0, 32'(detect2),  32'd1);

    // Reset pulsed between edges mid-stream.
    rst = 1'b1;
    tick();
    rst = 1'b0; oe = 1'b1; din = 1'b1; overlap = 1'b1;
    tick(); tick(); tick();
    check("pre_rst_det", 0, 32'(detect), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_det", 0, 32'(detect),  32'd0);
    check("async_rst_arm", 0, 32'(armed),   32'd0);
    check("async_rst_cnt", 0, 32'(hit_cnt), 32'd0);
    #1 rst = 1'b0;
    tick();
    check("post_rst_det1", 0, 32'(detect), 32'd0);
    check("post_rst_arm1", 0, 32'(armed),  32'd0);
    tick();
    check("post_rst_det2", 0, 32'(detect), 32'd0);
    tick();
    check("post_rst_det3", 0, 32'(detect),  32'd1);
    check("post_rst_cnt3", 0, 32'(hit_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
